// File: rtl/lfsr_prng.sv
// lfsr_prng: parametrised Fibonacci LFSR pseudo-random source with a
// valid/ready output stream. The state shifts left and the feedback bit
// enters at bit 0. STEPS shifts separate consecutive delivered words.
// A seed load has priority over everything else. Loading the lock-up value
// substitutes SEED and pulses lockup for one cycle.
// Optional feature macro: LFSR_PRNG_WORD_COUNT_EN adds the word_count output,
// which counts accepted words.
module lfsr_prng #(
  parameter int          WIDTH = 32,
  parameter logic [63:0] TAPS  = 64'h0000_0000_8020_0003,
  parameter logic [63:0] SEED  = 64'h0000_0000_0073_00F6,
  parameter bit          XNOR  = 1'b1,
  parameter int          STEPS = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             lockup
`ifdef LFSR_PRNG_WORD_COUNT_EN
  ,
  output logic [31:0]      word_count
`endif
);

  localparam logic [WIDTH-1:0] TAPS_W    = TAPS[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED_W    = SEED[WIDTH-1:0];
  // XNOR feedback can never leave the all-ones state; XOR feedback can never leave all-zeros.
  localparam logic [WIDTH-1:0] LOCK_VAL  = {WIDTH{XNOR}};
  localparam logic [7:0]       LAST_STEP = 8'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    STEP = 2'd2
  } state_t;

  state_t           r_fsm;
  state_t           w_fsm_next;
  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] w_state_next;
  logic [WIDTH-1:0] w_shifted;
  logic [7:0]       r_cnt;
  logic [7:0]       w_cnt_next;
  logic             r_lockup;
  logic             w_lockup_next;
  logic             w_fb;
  logic             w_hs;
  logic             w_seed_locked;

  assign w_fb          = (^(r_state & TAPS_W)) ^ XNOR;
  assign w_shifted     = {r_state[WIDTH-2:0], w_fb};
  assign w_hs          = (r_fsm == HOLD) && m_ready;
  assign w_seed_locked = (seed_in == LOCK_VAL);

  assign m_data  = r_state;
  assign m_valid = (r_fsm == HOLD);
  assign lockup  = r_lockup;

  // State register: FSM, LFSR state, inter-word step counter and lock-up pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fsm    <= IDLE;
      r_state  <= SEED_W;
      r_cnt    <= 8'd0;
      r_lockup <= 1'b0;
    end else begin
      r_fsm    <= w_fsm_next;
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_lockup <= w_lockup_next;
    end
  end

  // Next-state logic: a load overrides any handshake or step in progress.
  always_comb begin
    w_fsm_next    = r_fsm;
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_lockup_next = 1'b0;
    if (load) begin
      w_fsm_next    = IDLE;
      w_cnt_next    = 8'd0;
      w_state_next  = w_seed_locked ? SEED_W : seed_in;
      w_lockup_next = w_seed_locked;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (enable) w_fsm_next = HOLD;
        end
        HOLD: begin
          if (w_hs) begin
            w_state_next = w_shifted;
            if (STEPS == 1) begin
              w_fsm_next = enable ? HOLD : IDLE;
            end else begin
              w_fsm_next = STEP;
              w_cnt_next = 8'd1;
            end
          end
        end
        STEP: begin
          w_state_next = w_shifted;
          if (r_cnt == LAST_STEP) begin
            w_cnt_next = 8'd0;
            w_fsm_next = enable ? HOLD : IDLE;
          end else begin
            w_cnt_next = r_cnt + 8'd1;
          end
        end
        default: w_fsm_next = IDLE;
      endcase
    end
  end

`ifdef LFSR_PRNG_WORD_COUNT_EN
  logic [31:0] r_word_count;

  assign word_count = r_word_count;

  // Accepted-word counter; wraps naturally and is cleared by a load.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_word_count <= 32'd0;
    end else if (load) begin
      r_word_count <= 32'd0;
    end else if (w_hs) begin
      r_word_count <= r_word_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_prng.sv
// tb_lfsr_prng: three lfsr_prng instances (default; STEPS=3 with XOR
// feedback; STEPS=4 with XNOR feedback) share one stimulus stream. A per-word
// behavioural model predicts every cycle. Directed phases cover the listed
// scenarios, and a randomized phase follows them.
module tb_lfsr_prng;

  localparam logic [31:0] SEED = 32'h007300F6;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        load;
  logic        m_ready;
  logic [31:0] seed_in;

  logic [31:0] data_a, data_b, data_c;
  logic        valid_a, valid_b, valid_c;
  logic        lk_a, lk_b, lk_c;
`ifdef LFSR_PRNG_WORD_COUNT_EN
  logic [31:0] wc_a, wc_b, wc_c;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lfsr_prng dut_a (
    .clock(clk), .reset(rst), .enable(enable), .load(load), .seed_in(seed_in),
    .m_data(data_a), .m_valid(valid_a), .m_ready(m_ready), .lockup(lk_a)
`ifdef LFSR_PRNG_WORD_COUNT_EN
    , .word_count(wc_a)
`endif
  );

  lfsr_prng #(.STEPS(3), .XNOR(1'b0)) dut_b (
    .clock(clk), .reset(rst), .enable(enable), .load(load), .seed_in(seed_in),
    .m_data(data_b), .m_valid(valid_b), .m_ready(m_ready), .lockup(lk_b)
`ifdef LFSR_PRNG_WORD_COUNT_EN
    , .word_count(wc_b)
`endif
  );

  lfsr_prng #(.STEPS(4), .XNOR(1'b1)) dut_c (
    .clock(clk), .reset(rst), .enable(enable), .load(load), .seed_in(seed_in),
    .m_data(data_c), .m_valid(valid_c), .m_ready(m_ready), .lockup(lk_c)
`ifdef LFSR_PRNG_WORD_COUNT_EN
    , .word_count(wc_c)
`endif
  );

  // ---------------- reference model ----------------
  int          p_steps[3] = '{1, 3, 4};
  bit          p_xnor[3]  = '{1'b1, 1'b0, 1'b1};
  int          tap_pos[4] = '{31, 21, 1, 0};

  logic [31:0] m_st[3];
  bit          m_val[3];
  bit          m_lk[3];
  int          m_rem[3];   // shifts still owed before the next word is shown
  int unsigned m_wc[3];

  function automatic logic [31:0] succ(input logic [31:0] s, input bit xn);
    bit fb;
    fb = xn;
    foreach (tap_pos[i]) fb = fb ^ s[tap_pos[i]];
    return {s[30:0], fb};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_st[k]  = SEED;
      m_val[k] = 1'b0;
      m_lk[k]  = 1'b0;
      m_rem[k] = 0;
      m_wc[k]  = 0;
    end
  endtask

  task automatic model_step();
    logic [31:0] lv;
    for (int k = 0; k < 3; k++) begin
      if (load) begin
        lv       = p_xnor[k] ? 32'hFFFFFFFF : 32'h00000000;
        m_lk[k]  = (seed_in == lv);
        m_st[k]  = m_lk[k] ? SEED : seed_in;
        m_val[k] = 1'b0;
        m_rem[k] = 0;
        m_wc[k]  = 0;
      end else begin
        m_lk[k] = 1'b0;
        if (m_val[k]) begin
          if (m_ready) begin
            m_st[k] = succ(m_st[k], p_xnor[k]);
            m_wc[k] = m_wc[k] + 1;
            if (p_steps[k] == 1) begin
              m_val[k] = enable;
            end else begin
              m_val[k] = 1'b0;
              m_rem[k] = p_steps[k] - 1;
            end
          end
        end else if (m_rem[k] > 0) begin
          m_st[k]  = succ(m_st[k], p_xnor[k]);
          m_rem[k] = m_rem[k] - 1;
          if (m_rem[k] == 0) m_val[k] = enable;
        end else begin
          m_val[k] = enable;
        end
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dut_data(input int k);
    case (k)
      0:       return data_a;
      1:       return data_b;
      default: return data_c;
    endcase
  endfunction

  function automatic logic dut_valid(input int k);
    case (k)
      0:       return valid_a;
      1:       return valid_b;
      default: return valid_c;
    endcase
  endfunction

  function automatic logic dut_lk(input int k);
    case (k)
      0:       return lk_a;
      1:       return lk_b;
      default: return lk_c;
    endcase
  endfunction

`ifdef LFSR_PRNG_WORD_COUNT_EN
  function automatic logic [31:0] dut_wc(input int k);
    case (k)
      0:       return wc_a;
      1:       return wc_b;
      default: return wc_c;
    endcase
  endfunction
`endif

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("dut%0d.m_data", k), dut_data(k), m_st[k]);
      check($sformatf("dut%0d.m_valid", k), dut_valid(k), m_val[k]);
      check($sformatf("dut%0d.lockup", k), dut_lk(k), m_lk[k]);
`ifdef LFSR_PRNG_WORD_COUNT_EN
      check($sformatf("dut%0d.word_count", k), dut_wc(k), m_wc[k]);
`endif
    end
  endtask

  // One clock: the model advances with the inputs seen at the edge, then outputs are compared 1 ns later.
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int          hs_cyc[$];
  logic [31:0] hs_word[$];
  logic [31:0] exp_w;
  bit          found;

  initial begin
    rst     = 1'b1;
    enable  = 1'b0;
    load    = 1'b0;
    m_ready = 1'b0;
    seed_in = 32'h0;
    model_reset();
    #1;
    check("reset.m_data", data_a, SEED);
    check("reset.m_valid", valid_a, 1'b0);
    check("reset.lockup", lk_a, 1'b0);
    tick();
    tick();

    // Enable with backpressure, then release m_ready.
    rst    = 1'b0;
    enable = 1'b1;
    tick();
    $display("[TB] enable: valid=%0b data=%h", valid_a, data_a);
    check("first.valid", valid_a, 1'b1);
    check("first.word", data_a, 32'h007300F6);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp.word", data_a, 32'h007300F6);
      check("bp.valid", valid_a, 1'b1);
    end
    m_ready = 1'b1;
    tick();
    $display("[TB] accepted 007300f6, next=%h", data_a);
    check("word2", data_a, 32'h00E601ED);
    tick();
    $display("[TB] accepted 00e601ed, next=%h", data_a);
    check("word3", data_a, 32'h01CC03DB);

    // STEPS=3 spacing on dut_b from a fresh start.
    do_reset();
    for (int c = 0; c < 14; c++) begin
      tick();
      if (valid_b && m_ready) begin
        hs_cyc.push_back(c);
        hs_word.push_back(data_b);
        $display("[TB] steps3 word %h at cycle %0d", data_b, c);
      end
    end
    check("steps3.count", 64'(hs_cyc.size() >= 3), 64'd1);
    if (hs_cyc.size() >= 3) begin
      exp_w = succ(succ(succ(SEED, 1'b0), 1'b0), 1'b0);
      check("steps3.first", hs_word[0], SEED);
      check("steps3.second", hs_word[1], exp_w);
      check("steps3.gap1", 64'(hs_cyc[1] - hs_cyc[0]), 64'd3);
      check("steps3.gap2", 64'(hs_cyc[2] - hs_cyc[1]), 64'd3);
    end

    // Reset in the middle of dut_c's STEP phase.
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick();
      if (m_rem[2] > 0) found = 1'b1;
    end
    check("midstep.reached", 64'(found), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    $display("[TB] reset mid-step: valid=%0b data=%h", valid_c, data_c);
    check("midstep.valid", valid_c, 1'b0);
    check("midstep.data", data_c, SEED);
    model_reset();
    tick();
    rst = 1'b0;

    // Load a plain seed while holding a word.
    m_ready = 1'b0;
    tick();
    load    = 1'b1;
    seed_in = 32'h12345678;
    tick();
    load = 1'b0;
    $display("[TB] load 12345678: valid=%0b lockup=%0b", valid_a, lk_a);
    check("load.valid", valid_a, 1'b0);
    check("load.lockup", lk_a, 1'b0);
    tick();
    check("load.hold", valid_a, 1'b1);
    check("load.data", data_a, 32'h12345678);

    // Load the XNOR lock-up value, then the XOR lock-up value.
    load    = 1'b1;
    seed_in = 32'hFFFFFFFF;
    tick();
    load = 1'b0;
    $display("[TB] load ffffffff: data=%h lockup=%0b", data_a, lk_a);
    check("lockx.data", data_a, SEED);
    check("lockx.pulse", lk_a, 1'b1);
    check("lockx.pulse_c", lk_c, 1'b1);
    check("lockx.xor_plain", data_b, 32'hFFFFFFFF);
    tick();
    check("lockx.one_cycle", lk_a, 1'b0);
    load    = 1'b1;
    seed_in = 32'h00000000;
    tick();
    load = 1'b0;
    $display("[TB] load 00000000: data=%h lockup=%0b", data_b, lk_b);
    check("lock0.data", data_b, SEED);
    check("lock0.pulse", lk_b, 1'b1);
    tick();
    check("lock0.one_cycle", lk_b, 1'b0);

`ifdef LFSR_PRNG_WORD_COUNT_EN
    do_reset();
    m_ready = 1'b1;
    tick();
    check("wc.reset", wc_a, 32'd0);
    for (int i = 0; i < 10; i++) tick();
    $display("[TB] word_count after 10 handshakes: %0d", wc_a);
    check("wc.ten", wc_a, 32'd10);
`endif

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      enable  = ($urandom_range(0, 9) != 0);
      m_ready = ($urandom_range(0, 2) != 0);
      load    = ($urandom_range(0, 19) == 0);
      rst     = ($urandom_range(0, 149) == 0);
      case ($urandom_range(0, 3))
        0:       seed_in = 32'hFFFFFFFF;
        1:       seed_in = 32'h00000000;
        default: seed_in = $urandom;
      endcase
      if (load || rst) $display("[TB] rand cycle %0d: load=%0b rst=%0b seed=%h", i, load, rst, seed_in);
      tick();
    end
    rst  = 1'b0;
    load = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/lfsr_prng.md
Name: lfsr_prng

Overview:
- Parametrised Fibonacci LFSR pseudo-random source with a valid/ready output stream.
- Successor to the fixed 32-bit free-running LFSR. Adds generic width, taps, seed and XOR/XNOR mode, runtime seed load, enable, lock-up protection, and STEPS shifts per delivered word to decorrelate consecutive words.
- Feeds noise/dither and test-pattern consumers in the FPGA datapath through a stream handshake.

Parameters:
- WIDTH, 32, LFSR state and output width (4..64).
- TAPS, 32'h80200003, feedback tap mask; bit i set = state[i] in feedback. The default gives taps 31,21,1,0.
- SEED, 32'h007300F6, reset and substitute seed (WIDTH bits).
- XNOR, 1, 1 = XNOR feedback (lock-up state all ones); 0 = XOR feedback (lock-up state all zeros).
- STEPS, 1, shifts per delivered word (1..255).

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run request.
- load  in  1  single-cycle seed load strobe.
- seed_in  in  WIDTH  seed value, sampled when load=1.
- m_data  out  WIDTH  current LFSR state (output word).
- m_valid  out  1  m_data valid.
- m_ready  in  1  consumer accepts m_data.
- lockup  out  1  one-cycle pulse: the lock-up value was loaded and SEED was substituted.

Behaviour:
- Interface: one clock (clock); reset is asynchronous and active-high (reset).
- Shift rule: fb = ^(state & TAPS), inverted when XNOR=1; next = {state[WIDTH-2:0], fb}.
- Reset values: state=SEED, FSM=IDLE, step counter=0, m_valid=0, lockup=0. m_data=SEED because it always mirrors the state.
- FSM states: IDLE, HOLD, STEP.
  - IDLE: m_valid=0, no shift. If enable=1, go to HOLD next cycle. The first word delivered after reset is SEED.
  - HOLD: m_valid=1; m_data must stay stable while m_ready=0.
    - On handshake (m_valid & m_ready) the state shifts once in the same edge.
    - After a handshake with STEPS=1: stay in HOLD if enable=1, giving 1 word/cycle; otherwise go to IDLE.
    - After a handshake with STEPS>1: go to STEP with counter=1.
    - enable dropping in HOLD never retracts m_valid; it takes effect at the next handshake.
  - STEP: m_valid=0, shift every cycle, counter+1. On the shift where counter=STEPS-1, go to HOLD if enable=1, else IDLE.
  - Throughput: one word per STEPS cycles with m_ready held high.
- Load:
  - load has priority over shifting and handshake in every state.
  - state <= seed_in, counter=0, FSM goes to IDLE and m_valid drops next cycle. A handshake in the load cycle is discarded.
  - If seed_in equals the lock-up value, state <= SEED and lockup pulses high for 1 cycle (the cycle after load).
  - The next cycle re-enters HOLD per the IDLE rule, so the first word after a load is the loaded seed.
- Reset mid-operation: immediate return to reset values; the in-flight word is lost.
- TAPS must include bit WIDTH-1 so the state map is bijective and lock-up is unreachable except via load.

Optional Feature:
- Macro: LFSR_PRNG_WORD_COUNT_EN.
- Defined: adds output word_count [31:0], the count of handshakes.
  - Reset to 0 and cleared by load.
  - Increments on each accepted word; wraps from 32'hFFFFFFFF to 0.
  - Not incremented in a cycle where load=1.
- Undefined: no port and no counter logic. Behaviour is otherwise identical.

Test Plan:
- Defaults, reset release, enable=1, m_ready=1:
  - m_valid rises 1 cycle after enable.
  - Words are 0x007300F6, 0x00E601ED, 0x01CC03DB on consecutive cycles.
- Backpressure, m_ready=0 for 5 cycles in HOLD: m_data stays 0x007300F6 and m_valid stays 1. Next word is 0x00E601ED after m_ready=1.
- STEPS=3, m_ready=1:
  - Words are spaced 3 cycles apart.
  - Second word equals the third successor of SEED; m_valid=0 during the STEP cycles.
- load with seed_in=32'h12345678 in HOLD: m_valid=0 next cycle, then HOLD with m_data=32'h12345678. lockup stays 0.
- load with seed_in=32'hFFFFFFFF (XNOR=1): state=32'h007300F6 and lockup high for exactly 1 cycle. Repeat with XNOR=0 and seed_in=0.
- Reset asserted mid-STEP with STEPS=4: m_valid=0 and m_data=SEED immediately. With LFSR_PRNG_WORD_COUNT_EN defined, word_count=0 after reset and after 10 handshakes reads 10.
